// File: rtl/gradient_quantizer_pipe_pkg.sv
// Shared widths, quantizer level encodings and threshold reset values for the
// JPEG-LS gradient quantizer pipeline.
package gradient_quantizer_pipe_pkg;

   localparam int DEFAULT_PIXEL_LENGTH = 8;
   localparam int DEFAULT_QQ_LENGTH    = 4;
   localparam int DEFAULT_CTX_LENGTH   = 9;

   localparam int DEFAULT_T1   = 3;
   localparam int DEFAULT_T2   = 7;
   localparam int DEFAULT_T3   = 21;
   localparam int DEFAULT_NEAR = 0;

   typedef logic [DEFAULT_QQ_LENGTH-1:0] qq_t;

   // Two's complement encodings of the nine quantizer levels
   localparam qq_t QQ_NEG4 = 4'd12;
   localparam qq_t QQ_NEG3 = 4'd13;
   localparam qq_t QQ_NEG2 = 4'd14;
   localparam qq_t QQ_NEG1 = 4'd15;
   localparam qq_t QQ_ZERO = 4'd0;
   localparam qq_t QQ_POS1 = 4'd1;
   localparam qq_t QQ_POS2 = 4'd2;
   localparam qq_t QQ_POS3 = 4'd3;
   localparam qq_t QQ_POS4 = 4'd4;

   // A threshold set is usable only if it keeps the nine bins ordered.
   // The upper bound on T3 is implied by the register width.
   function automatic logic thresholds_valid(input int unsigned t1, input int unsigned t2,
                                             input int unsigned t3, input int unsigned near);
      return (near < t1) && (t1 <= t2) && (t2 <= t3);
   endfunction

endpackage

// File: rtl/gradient_quantizer_pipe_grad_quant.sv
// Single-gradient quantizer: maps one signed local gradient onto -4..4.
module grad_quant_one
   import gradient_quantizer_pipe_pkg::*;
#(
   parameter int PIXEL_LENGTH = DEFAULT_PIXEL_LENGTH
) (
   input  logic signed [PIXEL_LENGTH:0]   grad,
   input  logic        [PIXEL_LENGTH-1:0] t1,
   input  logic        [PIXEL_LENGTH-1:0] t2,
   input  logic        [PIXEL_LENGTH-1:0] t3,
   input  logic        [PIXEL_LENGTH-1:0] near,
   output qq_t                            q
);

   // One extra bit so negated thresholds and the gradient share a signed range
   localparam int W = PIXEL_LENGTH + 2;

   logic signed [W-1:0] g, t1_s, t2_s, t3_s, near_s;

   // Ordered bin search, first matching bin wins
   always_comb begin
      g      = W'(grad);
      t1_s   = signed'({2'b00, t1});
      t2_s   = signed'({2'b00, t2});
      t3_s   = signed'({2'b00, t3});
      near_s = signed'({2'b00, near});
      if      (g <= -t3_s)   q = QQ_NEG4;
      else if (g <= -t2_s)   q = QQ_NEG3;
      else if (g <= -t1_s)   q = QQ_NEG2;
      else if (g <  -near_s) q = QQ_NEG1;
      else if (g <=  near_s) q = QQ_ZERO;
      else if (g <   t1_s)   q = QQ_POS1;
      else if (g <   t2_s)   q = QQ_POS2;
      else if (g <   t3_s)   q = QQ_POS3;
      else                   q = QQ_POS4;
   end

endmodule

// File: rtl/gradient_quantizer_pipe.sv
// Two-stage JPEG-LS context front end: gradients and quantization in stage 1,
// sign merge and context index in stage 2, valid/ready on both sides.
module gradient_quantizer_pipe
   import gradient_quantizer_pipe_pkg::*;
#(
   parameter int PIXEL_LENGTH = DEFAULT_PIXEL_LENGTH,
   parameter int QQ_LENGTH    = DEFAULT_QQ_LENGTH,
   parameter int CTX_LENGTH   = DEFAULT_CTX_LENGTH,
   parameter int DEF_T1       = DEFAULT_T1,
   parameter int DEF_T2       = DEFAULT_T2,
   parameter int DEF_T3       = DEFAULT_T3,
   parameter int DEF_NEAR     = DEFAULT_NEAR
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [PIXEL_LENGTH-1:0] a,
   input  logic [PIXEL_LENGTH-1:0] b,
   input  logic [PIXEL_LENGTH-1:0] c,
   input  logic [PIXEL_LENGTH-1:0] d,
   input  logic                    cfg_load,
   input  logic [PIXEL_LENGTH-1:0] cfg_t1,
   input  logic [PIXEL_LENGTH-1:0] cfg_t2,
   input  logic [PIXEL_LENGTH-1:0] cfg_t3,
   input  logic [PIXEL_LENGTH-1:0] cfg_near,
   output logic                    cfg_err,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [QQ_LENGTH-1:0]    q1,
   output logic [QQ_LENGTH-1:0]    q2,
   output logic [QQ_LENGTH-1:0]    q3,
   output logic [CTX_LENGTH-1:0]   ctx_q,
   output logic                    sign,
   output logic                    run_flag
);

   localparam int CW = CTX_LENGTH + 2;

   logic                           s1_valid, s2_valid, adv1, adv2;
   logic [PIXEL_LENGTH-1:0]        t1_r, t2_r, t3_r, near_r;
   logic signed [PIXEL_LENGTH:0]   d1, d2, d3;
   qq_t                            rq1, rq2, rq3;
   qq_t                            s1_q1, s1_q2, s1_q3;
   logic                           neg;
   logic signed [QQ_LENGTH-1:0]    m1, m2, m3;
   logic signed [CW-1:0]           ctx_full;

   assign adv2     = !s2_valid || out_ready;
   assign adv1     = !s1_valid || adv2;
   assign in_ready = adv1;
   assign out_valid = s2_valid;

   assign d1 = signed'({1'b0, d}) - signed'({1'b0, b});
   assign d2 = signed'({1'b0, b}) - signed'({1'b0, c});
   assign d3 = signed'({1'b0, c}) - signed'({1'b0, a});

   grad_quant_one #(.PIXEL_LENGTH(PIXEL_LENGTH)) u_q1 (
      .grad(d1), .t1(t1_r), .t2(t2_r), .t3(t3_r), .near(near_r), .q(rq1));
   grad_quant_one #(.PIXEL_LENGTH(PIXEL_LENGTH)) u_q2 (
      .grad(d2), .t1(t1_r), .t2(t2_r), .t3(t3_r), .near(near_r), .q(rq2));
   grad_quant_one #(.PIXEL_LENGTH(PIXEL_LENGTH)) u_q3 (
      .grad(d3), .t1(t1_r), .t2(t2_r), .t3(t3_r), .near(near_r), .q(rq3));

   // Threshold registers: atomic update on a consistent set, sticky error otherwise
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         t1_r    <= PIXEL_LENGTH'(DEF_T1);
         t2_r    <= PIXEL_LENGTH'(DEF_T2);
         t3_r    <= PIXEL_LENGTH'(DEF_T3);
         near_r  <= PIXEL_LENGTH'(DEF_NEAR);
         cfg_err <= 1'b0;
      end else if (cfg_load) begin
         if (thresholds_valid(32'(cfg_t1), 32'(cfg_t2), 32'(cfg_t3), 32'(cfg_near))) begin
            t1_r   <= cfg_t1;
            t2_r   <= cfg_t2;
            t3_r   <= cfg_t3;
            near_r <= cfg_near;
         end else begin
            cfg_err <= 1'b1;
         end
      end
   end

   // Stage 1: capture raw quantized gradients of the accepted neighbour set
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_q1    <= '0;
         s1_q2    <= '0;
         s1_q3    <= '0;
      end else if (adv1) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_q1 <= rq1;
            s1_q2 <= rq2;
            s1_q3 <= rq3;
         end
      end
   end

   // Sign merge keyed on the first nonzero gradient, then the base-9 index
   always_comb begin
      if      (s1_q1 != '0) neg = s1_q1[QQ_LENGTH-1];
      else if (s1_q2 != '0) neg = s1_q2[QQ_LENGTH-1];
      else                  neg = s1_q3[QQ_LENGTH-1];
      m1 = neg ? -signed'(s1_q1) : signed'(s1_q1);
      m2 = neg ? -signed'(s1_q2) : signed'(s1_q2);
      m3 = neg ? -signed'(s1_q3) : signed'(s1_q3);
      ctx_full = CW'(m1) * CW'(81) + CW'(m2) * CW'(9) + CW'(m3);
   end

   // Stage 2: registered outputs, held while downstream stalls
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s2_valid <= 1'b0;
         q1       <= '0;
         q2       <= '0;
         q3       <= '0;
         ctx_q    <= '0;
         sign     <= 1'b0;
         run_flag <= 1'b0;
      end else if (adv2) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            q1       <= m1;
            q2       <= m2;
            q3       <= m3;
            ctx_q    <= ctx_full[CTX_LENGTH-1:0];
            sign     <= neg;
            run_flag <= (s1_q1 == '0) && (s1_q2 == '0) && (s1_q3 == '0);
         end
      end
   end

endmodule

// File: tb/tb_gradient_quantizer_pipe.sv
// Scoreboard bench for gradient_quantizer_pipe.
module tb_gradient_quantizer_pipe;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] a = '0, b = '0, c = '0, d = '0;
   logic       cfg_load = 1'b0;
   logic [7:0] cfg_t1 = '0, cfg_t2 = '0, cfg_t3 = '0, cfg_near = '0;
   logic       cfg_err;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [3:0] q1, q2, q3;
   logic [8:0] ctx_q;
   logic       sign;
   logic       run_flag;

   gradient_quantizer_pipe dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c(c), .d(d),
      .cfg_load(cfg_load), .cfg_t1(cfg_t1), .cfg_t2(cfg_t2), .cfg_t3(cfg_t3),
      .cfg_near(cfg_near), .cfg_err(cfg_err),
      .out_valid(out_valid), .out_ready(out_ready),
      .q1(q1), .q2(q2), .q3(q3), .ctx_q(ctx_q), .sign(sign), .run_flag(run_flag));

   always #5 clk = ~clk;

   typedef struct {
      int q1;
      int q2;
      int q3;
      int ctx;
      int sg;
      int rn;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   n_in = 0;
   int   n_out = 0;
   int   m_t1 = 3, m_t2 = 7, m_t3 = 21, m_near = 0;
   int   m_err = 0;
   bit   prev_stall = 1'b0;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int quant(input int g);
      if (g <= -m_t3)       return -4;
      else if (g <= -m_t2)  return -3;
      else if (g <= -m_t1)  return -2;
      else if (g < -m_near) return -1;
      else if (g <= m_near) return 0;
      else if (g < m_t1)    return 1;
      else if (g < m_t2)    return 2;
      else if (g < m_t3)    return 3;
      else                  return 4;
   endfunction

   function automatic exp_t model(input int av, input int bv, input int cv, input int dv);
      exp_t e;
      int   r1, r2, r3;
      bit   ng;
      r1 = quant(dv - bv);
      r2 = quant(bv - cv);
      r3 = quant(cv - av);
      if (r1 != 0)      ng = (r1 < 0);
      else if (r2 != 0) ng = (r2 < 0);
      else              ng = (r3 < 0);
      e.q1  = ng ? -r1 : r1;
      e.q2  = ng ? -r2 : r2;
      e.q3  = ng ? -r3 : r3;
      e.ctx = 81 * e.q1 + 9 * e.q2 + e.q3;
      e.sg  = ng ? 1 : 0;
      e.rn  = (r1 == 0 && r2 == 0 && r3 == 0) ? 1 : 0;
      return e;
   endfunction

   // Monitor: compare output against scoreboard head, push accepted inputs, track config
   always @(negedge clk) begin
      if (!reset_n) begin
         n_in -= sb.size();
         sb.delete();
         m_t1 = 3; m_t2 = 7; m_t3 = 21; m_near = 0;
         m_err = 0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) check("hold_valid", int'(out_valid), 1);
         check("in_ready", int'(in_ready), (sb.size() == 2 && !out_ready) ? 0 : 1);
         if (out_valid) begin
            if (sb.size() == 0) begin
               check("spurious_out_valid", int'(out_valid), 0);
            end else begin
               check("q1", int'($signed(q1)), sb[0].q1);
               check("q2", int'($signed(q2)), sb[0].q2);
               check("q3", int'($signed(q3)), sb[0].q3);
               check("ctx_q", int'(ctx_q), sb[0].ctx);
               check("sign", int'(sign), sb[0].sg);
               check("run_flag", int'(run_flag), sb[0].rn);
               if (out_ready) begin
                  void'(sb.pop_front());
                  n_out++;
               end
            end
         end
         prev_stall = out_valid && !out_ready;
         if (in_valid && in_ready) begin
            sb.push_back(model(int'(a), int'(b), int'(c), int'(d)));
            n_in++;
         end
         if (cfg_load) begin
            if (int'(cfg_near) < int'(cfg_t1) && cfg_t1 <= cfg_t2 && cfg_t2 <= cfg_t3) begin
               m_t1 = int'(cfg_t1); m_t2 = int'(cfg_t2);
               m_t3 = int'(cfg_t3); m_near = int'(cfg_near);
            end else begin
               m_err = 1;
            end
         end
      end
   end

   task automatic send(input int av, input int bv, input int cv, input int dv);
      bit got = 1'b0;
      a = 8'(av); b = 8'(bv); c = 8'(cv); d = 8'(dv);
      in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) check("send_timeout", int'(in_ready), 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic load_cfg(input int t1, input int t2, input int t3, input int nr);
      cfg_t1 = 8'(t1); cfg_t2 = 8'(t2); cfg_t3 = 8'(t3); cfg_near = 8'(nr);
      cfg_load = 1'b1;
      @(posedge clk);
      #1 cfg_load = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      check("drain_empty", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got time %0t expected finish earlier", $time);
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_cfg_err", int'(cfg_err), 0);
      check("rst_ctx_q", int'(ctx_q), 0);
      check("rst_q1", int'(q1), 0);
      check("rst_sign", int'(sign), 0);
      check("rst_run_flag", int'(run_flag), 0);

      send(100, 100, 100, 100);
      send(10, 20, 10, 40);
      send(10, 20, 30, 0);
      send(0, 0, 255, 255);
      send(255, 255, 0, 0);
      send(0, 10, 8, 13);
      drain();

      load_cfg(8, 7, 21, 0);
      check("bad_cfg_err", int'(cfg_err), m_err);
      send(0, 10, 8, 13);
      drain();

      fork
         load_cfg(5, 10, 25, 2);
         send(0, 10, 8, 12);
      join
      send(0, 10, 8, 12);
      send(0, 10, 8, 13);
      drain();

      fork
         begin
            send(10, 20, 10, 40);
            send(10, 20, 30, 0);
            send(0, 10, 8, 12);
            send(100, 100, 100, 100);
         end
         begin
            repeat (2) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();

      fork
         begin
            send(10, 20, 10, 40);
            send(10, 20, 30, 0);
            send(0, 10, 8, 13);
         end
         begin
            repeat (2) @(posedge clk);
            #1 reset_n = 1'b0;
            @(posedge clk);
            #1 reset_n = 1'b1;
         end
      join
      check("mid_rst_out_valid", int'(out_valid), 0);
      check("mid_rst_cfg_err", int'(cfg_err), 0);
      check("mid_rst_in_ready", int'(in_ready), 1);
      send(0, 10, 8, 13);
      send(0, 10, 8, 12);
      drain();

      check("io_count", n_out, n_in);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gradient_quantizer_pipe.md
Name: gradient_quantizer_pipe

Overview:
- Pipelined, runtime-configurable successor to the combinational gradient quantizer for the JPEG-LS context-modelling front end.
- Computes local gradients from neighbours a, b, c, d and quantizes them with programmable T1/T2/T3 and NEAR (near-lossless).
- Applies sign merging and emits the merged context index Q (0..364), the sign and a run-mode flag.
- Sits between the neighbourhood/line-buffer stage and the context-statistics RAM. Uses a valid/ready stream handshake.

Parameters:
- PIXEL_LENGTH, 8, sample width in bits.
- QQ_LENGTH, 4, width of each quantized gradient (two's complement, -4..4).
- CTX_LENGTH, 9, width of the merged context index.
- DEF_T1, 3, T1 reset value.
- DEF_T2, 7, T2 reset value.
- DEF_T3, 21, T3 reset value.
- DEF_NEAR, 0, NEAR reset value.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; one clock, synchronous, active-low.
- in_valid  in  1  neighbour set valid.
- in_ready  out  1  block can accept.
- a, b, c, d  in  PIXEL_LENGTH each  neighbour samples.
- cfg_load  in  1  one-cycle pulse; load thresholds.
- cfg_t1, cfg_t2, cfg_t3, cfg_near  in  PIXEL_LENGTH each  new threshold values.
- cfg_err  out  1  sticky; a rejected configuration was presented.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- q1, q2, q3  out  QQ_LENGTH each  sign-merged quantized gradients.
- ctx_q  out  CTX_LENGTH  merged index, 81*q1 + 9*q2 + q3.
- sign  out  1  1 = gradients were negated.
- run_flag  out  1  all raw quantized gradients are 0.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - Both stage valids clear. out_valid=0, all outputs 0, cfg_err=0.
  - Threshold registers take the DEF_* values.
  - in_ready=1 in the first cycle after reset.
- Reset has priority over every other input. Data in flight is discarded.
- Gradients (stage 1): signed, PIXEL_LENGTH+1 bits, no saturation.
  - D1 = d - b
  - D2 = b - c
  - D3 = c - a
- Quantization (stage 1), same rule for each Di, first match wins:
  - Di <= -T3 → -4
  - Di <= -T2 → -3
  - Di <= -T1 → -2
  - Di < -NEAR → -1
  - Di <= NEAR → 0
  - Di < T1 → 1
  - Di < T2 → 2
  - Di < T3 → 3
  - otherwise → 4
- Stage 1 registers the raw q values together with its valid.
- Merge (stage 2):
  - If the first nonzero of (q1, q2, q3) is negative, negate all three and set sign=1. Otherwise pass them through and set sign=0.
  - ctx_q = 81*q1 + 9*q2 + q3, computed on the merged values. Range 0..364 is guaranteed.
  - run_flag = 1 iff all three raw q values are 0. In that case ctx_q=0 and sign=0.
- Latency: 2 cycles from in_valid&&in_ready to out_valid when there is no stall. Throughput is 1 per cycle.
- Handshake:
  - adv2 = !s2_valid || out_ready
  - adv1 = !s1_valid || adv2
  - in_ready = adv1
- Stall behaviour:
  - Outputs hold stable while out_valid && !out_ready.
  - out_valid never drops without a transfer.
  - in_ready is combinational from out_ready and the stage valids. There is no skid buffer.
- Configuration:
  - cfg_load is accepted only if 0 <= NEAR < T1 <= T2 <= T3 and T3 < 2^PIXEL_LENGTH. On accept, all four registers update at that edge.
  - An invalid set leaves the registers unchanged and sets cfg_err. cfg_err clears only on reset.
  - A sample accepted in the same cycle as cfg_load is quantized with the old thresholds. The next accepted sample uses the new ones.
  - Samples already in stage 1 or stage 2 are unaffected by a load.
- Full-scale operands: D = ±(2^PIXEL_LENGTH - 1) quantizes to ±4. There is no overflow in the gradient width.

Decomposition:
- Shared package/header:
  - Add PIXEL_LENGTH, QQ_LENGTH and CTX_LENGTH defaults to the existing parameter include.
  - Add the encoded constants QQ_NEG4..QQ_POS4 (12..15, 0..4) and the default thresholds.
- One sub-module: grad_quant_one (pure combinational; one signed Di plus thresholds → q). Instantiate it three times in stage 1.
- Sign merge and index arithmetic stay in the top-level stage 2.

Test Plan:
- Flat region, default thresholds: a=b=c=d=100 → two cycles later q=(0,0,0), ctx_q=0, sign=0, run_flag=1.
- Positive gradients: a=10, b=20, c=10, d=40. D=(20,10,0) → q=(3,3,0), ctx_q=270, sign=0, run_flag=0.
- Sign merge: a=10, b=20, c=30, d=0. D=(-20,-10,20) → raw (-3,-3,3), merged (3,3,-3), ctx_q=267, sign=1.
- Near-lossless: cfg_load with T1=5, T2=10, T3=25, NEAR=2, then a=0, b=10, c=8, d=12.
  - D=(2,2,8) → q=(0,0,2), ctx_q=2, sign=0, run_flag=0.
  - Same config, D1=3 → q1=1.
- Backpressure: stream 4 samples back-to-back with out_ready low for 3 cycles mid-stream.
  - Outputs stay stable and in_ready drops within one cycle.
  - All 4 results appear in order, with no loss or duplication.
- Bad config and reset:
  - cfg_load with T1=8, T2=7 → cfg_err=1, thresholds unchanged (next result uses 3/7/21).
  - reset_n low mid-stream → out_valid=0, cfg_err=0 and DEF thresholds on the next cycle.
